// File: rtl/flash_resp_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, FSM states and
// timing constants used by the responder and future SPI targets.
package flash_resp_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;

  // Minimum SCLK high/low phase, in system clock cycles.
  localparam int SCLK_MIN_HALF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_ID,
    ST_STATUS,
    ST_IGNORE
  } resp_state_e;

  function automatic logic is_supported_op(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_RDID) || (op == OP_RDSR);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Oversamples the asynchronous SPI pins in the system clock domain and
// produces single-cycle SCLK edge strobes plus a synchronized chip select.
module spi_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_active,
  output logic mosi_s
);

  logic sclk_m, sclk_q, sclk_qq;
  logic cs_m, cs_q;
  logic mosi_m, mosi_q;

  // Two-flop synchronizers; SCLK gets a third stage for edge detection.
  // Chip select resets to the deasserted level so busy starts low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_m  <= 1'b0;
      sclk_q  <= 1'b0;
      sclk_qq <= 1'b0;
      cs_m    <= 1'b1;
      cs_q    <= 1'b1;
      mosi_m  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      sclk_m  <= sclk;
      sclk_q  <= sclk_m;
      sclk_qq <= sclk_q;
      cs_m    <= cs_n;
      cs_q    <= cs_m;
      mosi_m  <= mosi;
      mosi_q  <= mosi_m;
    end
  end

  assign sclk_rise = sclk_q & ~sclk_qq;
  assign sclk_fall = ~sclk_q & sclk_qq;
  assign cs_active = ~cs_q;
  assign mosi_s    = mosi_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash emulator: answers READ, RDID and RDSR from a byte memory
// port so the acquisition master can be exercised without external storage.
module spi_flash_responder
  import flash_resp_pkg::*;
#(
  parameter int          ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4017
) (
  input  logic              CLK_40,
  input  logic              reset_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  logic rise, fall, cs_act, mosi_s;
  logic rise_g, fall_g;

  resp_state_e state, state_nxt;

  logic [4:0]        bit_cnt;
  logic [22:0]       rx_sh;
  logic [23:0]       rx_next;
  logic [7:0]        opcode;
  logic [ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0] addr_ptr;
  logic [7:0]        tx_sh;
  logic [2:0]        tx_cnt;
  logic [7:0]        fetch_buf;
  logic [1:0]        byte_idx;
  logic              rd_d1;
  logic              first_load;
  logic              miso_q;

  logic       shift_in, op_done, addr_done, prefetch, tx_shift;
  logic [7:0] next_byte;

  spi_edge_sync u_sync (
    .clk       (CLK_40),
    .rst_n     (reset_n),
    .sclk      (spi_sclk),
    .cs_n      (spi_cs_n),
    .mosi      (spi_mosi),
    .sclk_rise (rise),
    .sclk_fall (fall),
    .cs_active (cs_act),
    .mosi_s    (mosi_s)
  );

  // A deasserted chip select masks any SCLK edge seen in the same cycle.
  assign rise_g  = rise & cs_act;
  assign fall_g  = fall & cs_act;
  assign rx_next = {rx_sh, mosi_s};
  assign opcode  = rx_next[7:0];
  assign addr_in = rx_next[ADDR_W-1:0];

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!cs_act) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: state_nxt = ST_CMD;
        ST_CMD: begin
          if (rise_g && bit_cnt == 5'd7) begin
            unique case (opcode)
              OP_READ: state_nxt = ST_ADDR;
              OP_RDID: state_nxt = ST_ID;
              OP_RDSR: state_nxt = ST_STATUS;
              default: state_nxt = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: if (rise_g && bit_cnt == 5'd23) state_nxt = ST_DATA;
        default: state_nxt = state;
      endcase
    end
  end

  // Per-state control strobes; prefetch fires on the first sampling rise of
  // each byte so the next byte is buffered long before it is needed.
  always_comb begin
    shift_in  = 1'b0;
    op_done   = 1'b0;
    addr_done = 1'b0;
    prefetch  = 1'b0;
    tx_shift  = 1'b0;
    next_byte = 8'hFF;
    unique case (state)
      ST_CMD: begin
        shift_in = rise_g;
        op_done  = rise_g && bit_cnt == 5'd7;
      end
      ST_ADDR: begin
        shift_in  = rise_g;
        addr_done = rise_g && bit_cnt == 5'd23;
      end
      ST_DATA: begin
        prefetch  = rise_g && tx_cnt == 3'd1;
        tx_shift  = fall_g;
        next_byte = fetch_buf;
      end
      ST_ID: begin
        tx_shift = fall_g;
        unique case (byte_idx)
          2'd1:    next_byte = JEDEC_ID[15:8];
          2'd2:    next_byte = JEDEC_ID[7:0];
          default: next_byte = 8'hFF;
        endcase
      end
      ST_STATUS: begin
        tx_shift  = fall_g;
        next_byte = 8'h00;
      end
      default: begin
        shift_in = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      rx_sh      <= '0;
      addr_ptr   <= '0;
      tx_sh      <= 8'hFF;
      tx_cnt     <= '0;
      fetch_buf  <= '0;
      byte_idx   <= '0;
      rd_d1      <= 1'b0;
      first_load <= 1'b0;
      miso_q     <= 1'b1;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      cmd_err    <= 1'b0;
    end else if (!cs_act) begin
      bit_cnt    <= '0;
      rx_sh      <= '0;
      tx_sh      <= 8'hFF;
      tx_cnt     <= '0;
      fetch_buf  <= '0;
      byte_idx   <= '0;
      rd_d1      <= 1'b0;
      first_load <= 1'b0;
      miso_q     <= 1'b1;
      mem_rd     <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      mem_rd  <= 1'b0;
      cmd_err <= 1'b0;
      rd_d1   <= mem_rd;
      if (shift_in) begin
        rx_sh   <= rx_next[22:0];
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (op_done) begin
        bit_cnt <= '0;
        cmd_err <= !is_supported_op(opcode);
        if (opcode == OP_RDID) begin
          tx_sh    <= JEDEC_ID[23:16];
          byte_idx <= 2'd1;
        end else if (opcode == OP_RDSR) begin
          tx_sh <= 8'h00;
        end
      end
      if (addr_done) begin
        mem_rd     <= 1'b1;
        mem_addr   <= addr_in;
        addr_ptr   <= addr_in + ADDR_W'(1);
        first_load <= 1'b1;
      end
      if (prefetch) begin
        mem_rd   <= 1'b1;
        mem_addr <= addr_ptr;
        addr_ptr <= addr_ptr + ADDR_W'(1);
      end
      // The first read of a burst goes straight to the shifter; later ones
      // wait in fetch_buf until the current byte has been shifted out.
      if (rd_d1) begin
        if (first_load) begin
          tx_sh      <= mem_rdata;
          first_load <= 1'b0;
        end else begin
          fetch_buf <= mem_rdata;
        end
      end
      if (tx_shift) begin
        miso_q <= tx_sh[7];
        tx_cnt <= tx_cnt + 3'd1;
        if (tx_cnt == 3'd7) begin
          tx_sh <= next_byte;
          if (byte_idx != 2'd3) byte_idx <= byte_idx + 2'd1;
        end else begin
          tx_sh <= {tx_sh[6:0], 1'b1};
        end
      end
    end
  end

  assign spi_miso = miso_q;
  assign busy     = cs_act;

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI target (mode 0) that plays the flash/SD side of the video data-acquisition link, answering the SPI master's frame-data reads from an on-chip memory port. It sits on the GPIO header, wired to the master's MOSI, chip_select and SPI_clk lines, and drives MISO back. This gives in-system playback tests without external storage. All SPI inputs are oversampled in the CLK_40 domain; there is no second clock domain.

## Interface
- ADDR_W, 24: width of the flash address and of mem_addr; address wraps modulo 2^ADDR_W.
- JEDEC_ID, 24'hEF4017: three bytes returned MSB-first by command 0x9F.
- CLK_40  input  1  system clock, 40 MHz.
- reset_n  input  1  reset: one clock; reset is asynchronous and active-low.
- spi_sclk  input  1  SPI clock from master, asynchronous; idle low.
- spi_cs_n  input  1  chip select, active-low, asynchronous.
- spi_mosi  input  1  master-out data, asynchronous.
- spi_miso  output  1  target-out data; 1 whenever no data bit is being driven.
- mem_rd  output  1  one-cycle read strobe to byte memory.
- mem_addr  output  ADDR_W  byte address, valid while mem_rd is high.
- mem_rdata  input  8  read data, valid exactly one cycle after mem_rd.
- busy  output  1  high while a synchronized cs_n is low.
- cmd_err  output  1  one-cycle pulse when an unsupported opcode completes.

## Operation
- **Input conditioning:** two-flop synchronizer on sclk, cs_n and mosi, then one registered stage for edge detection.
  - rise = sclk_q & ~sclk_qq; fall = ~sclk_q & sclk_qq.
- **Sampling:** MOSI is sampled on rise and shifted in MSB-first. MISO changes only on fall, or on the load at the start of a data phase.
- **States:**
  - IDLE
    - cs low → CMD; bit counter cleared.
  - CMD
    - Collect 8 bits.
    - 0x03 → ADDR.
    - 0x9F → ID.
    - 0x05 → STATUS.
    - Anything else → IGNORE and pulse cmd_err.
  - ADDR
    - Collect 24 bits. The address register keeps the low ADDR_W bits.
    - After bit 24, issue mem_rd with mem_addr = address, then go to DATA.
  - DATA
    - Two cycles after mem_rd, load mem_rdata into the tx shift register. The next fall drives its MSB.
    - After the 8th fall of a byte, load the prefetched next byte.
    - Prefetch mem_rd is issued on the rise of bit 0 of the current byte, with the address incremented.
    - Stream continues indefinitely; the address wraps from 2^ADDR_W−1 to 0.
  - ID: shift out the JEDEC_ID bytes. After 3 bytes, MISO stays 1.
  - STATUS: shift out 0x00 repeatedly; the device is never busy.
  - IGNORE: MISO held at 1 until cs rises.
- **CS deassert in any state:** next cycle go to IDLE, spi_miso=1, counters and shift registers cleared, any in-flight prefetch discarded.
- **Reset values:**
  - spi_miso=1, mem_rd=0, mem_addr=0, busy=0, cmd_err=0, state IDLE.
  - Asynchronous reset during a transfer aborts it. The master must re-assert cs to start again.
- **Simultaneous events:** cs rising in the same synchronized cycle as an sclk edge: cs wins and the edge is ignored.

## Timing
- Input-to-decision latency: 3 CLK_40 cycles (2 sync + 1 edge register).
- Requirement: SCLK high and low phases ≥ 8 CLK_40 cycles each (≤ 2.5 MHz). The 1 MHz SPI_clk_en rate gives 20.
- First read-data MSB is driven on the first fall after the 32nd rise; memory data is loaded ≤ 3 cycles after that rise.
- mem_rd is exactly 1 cycle wide, at most one per byte. mem_rdata is captured on cycle mem_rd+1.
- busy follows cs with 2-cycle latency. cmd_err is asserted the cycle after the 8th opcode bit is sampled.

## Structure
- Shared package flash_resp_pkg holds:
  - opcode constants OP_READ=8'h03, OP_RDID=8'h9F, OP_RDSR=8'h05;
  - state enum resp_state_e;
  - SCLK_MIN_HALF=8.
- One sub-module, spi_edge_sync: synchronizers plus rise/fall/cs detection, shared with future SPI targets.

## Test plan
- **Read at 0x000100:** opcode 0x03 plus address, memory model returns addr[7:0]. Clock 4 bytes → MISO bytes 0x00,0x01,0x02,0x03; mem_addr 0x100..0x103, one mem_rd per byte.
- **Wrap:** read at 0xFFFFFE for 3 bytes → mem_addr 0xFFFFFE, 0xFFFFFF, 0x000000.
- **RDID:** 0x9F then 32 clocks → bytes 0xEF,0x40,0x17,0xFF. RDSR 0x05 then 16 clocks → 0x00,0x00.
- **Bad opcode 0xAB:** cmd_err pulses once for one cycle, MISO stays 1, no mem_rd.
- **CS abort:** raise cs after 12 address bits, then issue a fresh read at 0x000010 → first byte 0x10; no stale mem_rd.
- **reset_n asserted mid-DATA:** all outputs take reset values immediately. After release, a fresh read at 0x000005 returns 0x05.
